// File: rtl/reduce_sched.sv
`default_nettype none
// ============================================================================
// Module      : reduce_sched
// Description : Two-requester round-robin scheduler for a shared column-mean
//               reduce unit. Grants one requester, routes its operand matrix to
//               the reduce unit, waits for the done pulse (with a timeout), then
//               holds the latched result until downstream accepts it.
// Ports       : clk, rst            - clock, async active-high reset
//               req_i               - per-requester job request
//               matrix0_i/matrix1_i - 16x16 signed 8-bit operands, element
//                                     (r,c) at bits [(r*16+c)*8 +: 8]
//               gnt_o               - one-hot grant
//               red_enable_o, red_matrix_o, red_clr_o - reduce unit control
//               red_done_i, red_result_i - reduce unit done / column means,
//                                     column c at bits [c*8 +: 8]
//               res_valid_o/res_ready_i/res_data_o/res_id_o - result handoff
//               busy_o, err_timeout_o, err_clr_i, job_cnt_o - status
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_sched #(
    parameter int TIMEOUT_CYC = 400
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_i,
    input  logic [2047:0] matrix0_i,
    input  logic [2047:0] matrix1_i,
    output logic [1:0]    gnt_o,
    output logic          red_enable_o,
    output logic [2047:0] red_matrix_o,
    output logic          red_clr_o,
    input  logic          red_done_i,
    input  logic [127:0]  red_result_i,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [127:0]  res_data_o,
    output logic          res_id_o,
    output logic          busy_o,
    output logic          err_timeout_o,
    input  logic          err_clr_i,
    output logic [15:0]   job_cnt_o
);

    localparam logic [8:0] c_TIMEOUT_LAST = 9'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        OUT   = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;     // requester served most recently
    logic [8:0]     cnt_q, cnt_d;
    logic [127:0]   res_data_q, res_data_d;
    logic           res_id_q, res_id_d;
    logic [15:0]    job_cnt_q, job_cnt_d;
    logic           err_q, err_d;

    logic           w_arb_owner;
    logic           w_sel_owner;
    logic [1:0]     w_gnt;

    // With both requests pending, the one not served last wins. After reset
    // last_q=1 so requester 0 is preferred.
    assign w_arb_owner = (req_i == 2'b11) ? ~last_q : req_i[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= 9'd0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            job_cnt_q  <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            job_cnt_q  <= job_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        job_cnt_d  = job_cnt_q;
        err_d      = err_q;
        // Clear first so a timeout in the same cycle overrides it.
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    owner_d = w_arb_owner;
                    cnt_d   = 9'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 9'd1;
                if (red_done_i) begin
                    res_data_d = red_result_i;
                    res_id_d   = owner_q;
                    state_d    = OUT;
                end else if (cnt_q == c_TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ABORT;
                end
            end
            OUT: begin
                if (res_ready_i) begin
                    job_cnt_d = job_cnt_q + 16'd1;
                    last_d    = owner_q;
                    state_d   = IDLE;
                end
            end
            ABORT: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The grant is visible in the IDLE cycle where the request is sampled, so
    // the reduce unit sees its operand one cycle before enable rises. The rst
    // term keeps the combinational grant at zero while reset is held.
    always_comb begin
        w_gnt       = 2'b00;
        w_sel_owner = owner_q;
        case (state_q)
            IDLE: begin
                w_sel_owner = w_arb_owner;
                if (!rst && (|req_i)) begin
                    w_gnt = {w_arb_owner, ~w_arb_owner};
                end
            end
            RUN, OUT: w_gnt = {owner_q, ~owner_q};
            default:  w_gnt = 2'b00;
        endcase
    end

    assign gnt_o         = w_gnt;
    assign red_matrix_o  = (|w_gnt) ? (w_sel_owner ? matrix1_i : matrix0_i) : '0;
    assign red_enable_o  = (state_q == RUN);
    assign red_clr_o     = (state_q == ABORT);
    assign res_valid_o   = (state_q == OUT);
    assign busy_o        = (state_q != IDLE);
    assign res_data_o    = res_data_q;
    assign res_id_o      = res_id_q;
    assign err_timeout_o = err_q;
    assign job_cnt_o     = job_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reduce_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_reduce_sched
// Description : Directed self-checking bench for reduce_sched with a simple
//               column-mean reduce-unit model and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reduce_sched;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [2047:0] m0, m1;
    logic [1:0]    gnt;
    logic          red_enable;
    logic [2047:0] red_matrix;
    logic          red_clr;
    logic          red_done;
    logic [127:0]  red_result;
    logic          res_valid;
    logic          res_ready;
    logic [127:0]  res_data;
    logic          res_id;
    logic          busy;
    logic          err_timeout;
    logic          err_clr;
    logic [15:0]   job_cnt;

    always #5 clk = ~clk;

    reduce_sched #(.TIMEOUT_CYC(400)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .matrix0_i    (m0),
        .matrix1_i    (m1),
        .gnt_o        (gnt),
        .red_enable_o (red_enable),
        .red_matrix_o (red_matrix),
        .red_clr_o    (red_clr),
        .red_done_i   (red_done),
        .red_result_i (red_result),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .res_id_o     (res_id),
        .busy_o       (busy),
        .err_timeout_o(err_timeout),
        .err_clr_i    (err_clr),
        .job_cnt_o    (job_cnt)
    );

    // ---------------- reduce unit model: done on 273rd enabled cycle --------
    logic [8:0] m_ecnt;
    logic       m_kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       m_ecnt <= 9'd0;
        else if (red_clr || !red_enable) m_ecnt <= 9'd0;
        else                           m_ecnt <= m_ecnt + 9'd1;
    end

    function automatic logic [127:0] col_means(input logic [2047:0] m);
        logic [127:0] cm;
        int s;
        cm = '0;
        for (int c = 0; c < 16; c++) begin
            s = 0;
            for (int r = 0; r < 16; r++) s += int'($signed(m[(r*16+c)*8 +: 8]));
            cm[c*8 +: 8] = 8'(s / 16);
        end
        return cm;
    endfunction

    assign red_done   = red_enable && (m_ecnt == 9'd272) && !m_kill;
    assign red_result = col_means(red_matrix);

    // ---------------- helpers ----------------
    function automatic logic [2047:0] fill_all(input logic [7:0] v);
        logic [2047:0] f;
        for (int i = 0; i < 256; i++) f[i*8 +: 8] = v;
        return f;
    endfunction

    function automatic logic [2047:0] fill_cols();
        logic [2047:0] f;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) f[(r*16+c)*8 +: 8] = 8'(c - 8);
        return f;
    endfunction

    function automatic logic [127:0] rep16(input logic [7:0] v);
        logic [127:0] d;
        for (int j = 0; j < 16; j++) d[j*8 +: 8] = v;
        return d;
    endfunction

    function automatic logic [127:0] ramp16();
        logic [127:0] d;
        for (int j = 0; j < 16; j++) d[j*8 +: 8] = 8'(j - 8);
        return d;
    endfunction

    typedef struct {
        logic         id;
        logic [127:0] data;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE: drives req, checks the grant cycle, pushes
    // the expected result and follows the job until res_valid.
    task automatic do_job(input string nm, input logic [1:0] r, input logic [1:0] exp_gnt,
                          input logic [127:0] exp_data, input bit drop_req);
        int lat, en_at, bad;
        exp_t e;
        lat = 0; en_at = -1; bad = 0;
        req = r;
        #1;
        chk({nm, "_gnt"}, 128'(gnt), 128'(exp_gnt));
        chk({nm, "_en_at_grant"}, 128'(red_enable), 128'(0));
        chk({nm, "_red_matrix"}, 128'(red_matrix == (exp_gnt[1] ? m1 : m0)), 128'(1));
        e.id = exp_gnt[1];
        e.data = exp_data;
        sbq.push_back(e);
        while (!res_valid && lat < 600) begin
            @(negedge clk);
            lat++;
            if (drop_req) req = 2'b00;
            if (red_enable && en_at < 0) en_at = lat;
            if (gnt !== exp_gnt) bad++;
        end
        chk({nm, "_latency"}, 128'(lat), 128'(274));
        chk({nm, "_en_rise"}, 128'(en_at), 128'(1));
        chk({nm, "_gnt_held"}, 128'(bad), 128'(0));
    endtask

    // Called at a negedge in OUT: optional stall, scoreboard compare, handoff.
    task automatic take_result(input string nm, input int stall, input logic [15:0] exp_cnt);
        logic [127:0] d0;
        logic [1:0]   g0;
        int bad;
        exp_t e;
        d0 = res_data; g0 = gnt; bad = 0;
        res_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!res_valid || res_data !== d0 || gnt !== g0) bad++;
        end
        chk({nm, "_stall_stable"}, 128'(bad), 128'(0));
        if (sbq.size() > 0) e = sbq.pop_front();
        else begin e.id = 1'bx; e.data = 'x; end
        chk({nm, "_res_data"}, res_data, e.data);
        chk({nm, "_res_id"}, 128'(res_id), 128'(e.id));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({nm, "_job_cnt"}, 128'(job_cnt), 128'(exp_cnt));
        chk({nm, "_valid_low"}, 128'(res_valid), 128'(0));
        chk({nm, "_idle_en_low"}, 128'(red_enable), 128'(0));
        chk({nm, "_idle_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n_en, vseen;
        rst = 1'b1; req = 2'b11; res_ready = 1'b0; err_clr = 1'b0; m_kill = 1'b0;
        m0 = fill_all(8'd16);
        m1 = fill_cols();
        repeat (2) @(negedge clk);

        // Reset state (request held while in reset must not leak to gnt)
        chk("rst_gnt", 128'(gnt), 128'(0));
        chk("rst_matrix_zero", 128'(red_matrix == '0), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_enable", 128'(red_enable), 128'(0));
        chk("rst_valid", 128'(res_valid), 128'(0));
        chk("rst_job_cnt", 128'(job_cnt), 128'(0));
        chk("rst_err", 128'(err_timeout), 128'(0));
        chk("rst_res_data", res_data, 128'(0));
        rst = 1'b0;
        req = 2'b00;
        @(negedge clk);

        // Both requesting: requester 0 first, stalled handoff, then requester 1
        do_job("rr0", 2'b11, 2'b01, rep16(8'd16), 1'b0);
        take_result("rr0", 10, 16'd1);
        do_job("rr1", 2'b11, 2'b10, ramp16(), 1'b0);
        take_result("rr1", 0, 16'd2);

        // Single request on port 0, request dropped after grant
        do_job("single0", 2'b01, 2'b01, rep16(8'd16), 1'b1);
        take_result("single0", 0, 16'd3);

        // Timeout: reduce unit never finishes
        m_kill = 1'b1;
        req = 2'b10;
        #1;
        chk("to_gnt", 128'(gnt), 128'(2'b10));
        n_en = 0; vseen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            req = 2'b00;
            if (red_clr) break;
            if (red_enable) n_en++;
            if (res_valid) vseen++;
        end
        chk("to_run_cycles", 128'(n_en), 128'(400));
        chk("to_red_clr", 128'(red_clr), 128'(1));
        chk("to_abort_gnt", 128'(gnt), 128'(0));
        chk("to_err_set", 128'(err_timeout), 128'(1));
        chk("to_no_valid", 128'(vseen + int'(res_valid)), 128'(0));
        @(negedge clk);
        chk("to_clr_one_cycle", 128'(red_clr), 128'(0));
        chk("to_idle", 128'(busy), 128'(0));
        chk("to_job_cnt", 128'(job_cnt), 128'(3));
        chk("to_err_sticky", 128'(err_timeout), 128'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_err_clr", 128'(err_timeout), 128'(0));
        m_kill = 1'b0;

        // Asynchronous reset in the middle of RUN
        req = 2'b01;
        #1;
        chk("mid_gnt", 128'(gnt), 128'(2'b01));
        repeat (100) @(negedge clk);
        req = 2'b00;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 128'(gnt), 128'(0));
        chk("mid_rst_enable", 128'(red_enable), 128'(0));
        chk("mid_rst_matrix", 128'(red_matrix == '0), 128'(1));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_job_cnt", 128'(job_cnt), 128'(0));
        chk("mid_rst_valid", 128'(res_valid), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fresh job on requester 1 after reset
        do_job("post_rst", 2'b10, 2'b10, ramp16(), 1'b1);
        take_result("post_rst", 0, 16'd1);

        chk("sb_empty", 128'(sbq.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
